cdc_src_mc: RTL and testbench
=============================

# cdc_src_mc

Multi-channel, parametrised source half of a gray-pointer asynchronous FIFO. It replaces the fixed five-channel, depth-2 CDC source at the boundary between the host core cluster and the SoC clock domain. Each of `NumChan` independent channels buffers `2**LogDepth` words, publishes a registered gray write pointer, and synchronises the remote gray read pointer over a configurable number of stages. Over the fixed-depth predecessor it adds per-channel occupancy reporting and a clean isolate/drain handshake for clock-gating or reset of the destination domain.

## Interface
Parameters:
- `NumChan`, 5: number of independent channels (AW, W, B, AR, R style).
- `DataWidth`, 64: payload width per channel; narrower channels zero-pad the upper bits.
- `LogDepth`, 1: log2 of per-channel FIFO depth; minimum 1.
- `SyncStages`, 2: flip-flop stages on the read-pointer synchroniser; minimum 2.

Ports:
- `clk_i`  in  1  source-domain clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `src_valid_i`  in  NumChan  per-channel push request.
- `src_ready_o`  out  NumChan  per-channel push accept.
- `src_data_i`  in  NumChan×DataWidth  push payload.
- `async_data_o`  out  NumChan×2**LogDepth×DataWidth  FIFO storage, read by the destination.
- `async_wptr_o`  out  NumChan×(LogDepth+1)  registered gray write pointer.
- `async_rptr_i`  in  NumChan×(LogDepth+1)  gray read pointer from the destination domain (asynchronous).
- `fill_o`  out  NumChan×(LogDepth+1)  occupancy as seen in the source domain.
- `isolate_i`  in  1  request to stop accepting and drain.
- `isolated_o`  out  1  all channels empty while isolation is requested.

## Operation
- Per channel: binary write pointer `wbin` of LogDepth+1 bits. `async_wptr_o = wbin ^ (wbin >> 1)`, registered alongside it.
- Read pointer: `async_rptr_i` passes through SyncStages flops, each reset to 0. The last stage is converted gray→binary to give `rbin`.
- `fill = wbin - rbin`, taken modulo 2**(LogDepth+1). `full` is asserted when `fill == 2**LogDepth`. `fill_o` is combinational from the registered values.
- `src_ready_o[c] = !full[c] && !isolate_i`. This is combinational; there is no dependence on `src_valid_i`.
- Push on `src_valid_i[c] && src_ready_o[c]`:
  - the storage word at `wbin[LogDepth-1:0]` is written with `src_data_i[c]`;
  - `wbin` increments, wrapping naturally through 2**(LogDepth+1).
  - The data write and the pointer update occur on the same edge. Storage is never rewritten while its slot is occupied.
- Channels are fully independent. A push on one channel never affects another channel's pointers.
- Isolation: `isolated_o` is a register set to `isolate_i && (all fill == 0)` every cycle.
- `fill` values above 2**LogDepth are impossible by construction. The bench asserts against them.

## Timing
- Reset values: `wbin`, `async_wptr_o`, all storage, all sync flops, `fill_o` and `isolated_o` are 0. `src_ready_o` is all-1 while `isolate_i` is 0.
- Push at edge k: `async_wptr_o` and `fill_o` reflect the push after edge k.
- Read-pointer change at the input: it is visible in `fill_o` and `src_ready_o` after SyncStages rising edges.
- Simultaneous push and remote pop on a full channel: the pop is not yet synchronised, so ready stays 0 that cycle. There is no bypass.
- Assertion of `isolate_i`: ready drops in the same cycle. A beat presented in that cycle is not accepted.
- Assertion of `isolated_o`: one edge after the condition holds. It deasserts one edge after `isolate_i` falls.
- Reset mid-operation: all pointers return to 0 immediately. Destination-side reset is coordinated by the system through isolation.

## Configuration
- `CDC_SRC_ISOLATE_EN` defined:
  - isolation logic as described above.
- `CDC_SRC_ISOLATE_EN` undefined:
  - `isolate_i` is ignored and `src_ready_o = !full`;
  - `isolated_o` is tied to 0 and no isolation register is built.

## Test plan
- Reset with LogDepth=1: after release, `async_wptr_o = 00`, `fill_o = 0`, `src_ready_o = 5'b11111` and `isolated_o = 0`.
- Fill channel 0 with `async_rptr_i` held at 00 and three beats pushed (A, B, C):
  - A and B are accepted; `async_wptr_o` steps 00→01→11;
  - `fill_o[0] = 2`, `src_ready_o[0] = 0`, and C is stalled;
  - storage slots 0 and 1 hold A and B.
- Release one entry by setting `async_rptr_i[0] = 01`: `fill_o[0] = 1` and `src_ready_o[0] = 1` exactly 2 edges later (SyncStages = 2), then C is written to slot 0.
- Wrap-around with a destination model echoing `wptr` as `rptr`: 10 continuous pushes on channel 4.
  - The pointer cycles 00,01,11,10,00,… and every beat appears in slot `n mod 2`.
- Isolation with one entry pending on channel 1: raise `isolate_i`.
  - All ready go to 0 immediately and `isolated_o` stays 0.
  - Return `rptr` to drain; `isolated_o` becomes 1 two sync edges plus one edge later.
  - Without the macro, the same stimulus keeps ready at 1 and `isolated_o` at 0.
- Channel independence: push on channels 0 and 3 in the same cycle while channel 2 is full. Both are accepted, and channel 2's pointers and fill are unchanged.

Source files
------------

// File: rtl/cdc_src_mc_if.sv
// -----------------------------------------------------------------------------
// cdc_src_mc_if
//
// Purpose : bundles the push side and the asynchronous FIFO side of the
//           multi-channel CDC source so the source block and its environment
//           connect through one port.
//
// Signals (names follow the block's port list):
//   src_valid_i  [NumChan]                    push request per channel
//   src_ready_o  [NumChan]                    push accept per channel
//   src_data_i   [NumChan][DataWidth]         push payload
//   async_data_o [NumChan][Depth][DataWidth]  FIFO storage read by destination
//   async_wptr_o [NumChan][LogDepth+1]        registered gray write pointer
//   async_rptr_i [NumChan][LogDepth+1]        gray read pointer (asynchronous)
//   fill_o       [NumChan][LogDepth+1]        occupancy seen in source domain
//   isolate_i                                 stop accepting and drain
//   isolated_o                                all channels empty while isolated
//
// Modports:
//   master : environment side (drives pushes, read pointer, isolate request)
//   slave  : the cdc_src_mc block itself
// -----------------------------------------------------------------------------
interface cdc_src_mc_if #(
  parameter int unsigned NumChan   = 5,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LogDepth  = 1
);

  localparam int unsigned Depth = 2 ** LogDepth;
  localparam int unsigned PtrW  = LogDepth + 1;

  logic [NumChan-1:0]                             src_valid_i;
  logic [NumChan-1:0]                             src_ready_o;
  logic [NumChan-1:0][DataWidth-1:0]              src_data_i;
  logic [NumChan-1:0][Depth-1:0][DataWidth-1:0]   async_data_o;
  logic [NumChan-1:0][PtrW-1:0]                   async_wptr_o;
  logic [NumChan-1:0][PtrW-1:0]                   async_rptr_i;
  logic [NumChan-1:0][PtrW-1:0]                   fill_o;
  logic                                           isolate_i;
  logic                                           isolated_o;

  modport master (
    output src_valid_i,
    output src_data_i,
    output async_rptr_i,
    output isolate_i,
    input  src_ready_o,
    input  async_data_o,
    input  async_wptr_o,
    input  fill_o,
    input  isolated_o
  );

  modport slave (
    input  src_valid_i,
    input  src_data_i,
    input  async_rptr_i,
    input  isolate_i,
    output src_ready_o,
    output async_data_o,
    output async_wptr_o,
    output fill_o,
    output isolated_o
  );

endinterface

// File: rtl/cdc_src_mc.sv
// -----------------------------------------------------------------------------
// cdc_src_mc
//
// Purpose : source half of a multi-channel gray-pointer asynchronous FIFO.
//           Each of NumChan independent channels owns 2**LogDepth storage
//           words, publishes a registered gray write pointer and synchronises
//           the destination's gray read pointer through SyncStages flops.
//           Per-channel occupancy is reported in the source domain, and an
//           isolate/drain handshake lets the destination domain be gated or
//           reset safely.
//
// Ports:
//   clk_i   source-domain clock
//   rst_ni  asynchronous active-low reset
//   bus     cdc_src_mc_if.slave (push handshake, storage, pointers, fill,
//           isolate request / isolated status)
//
// Configuration:
//   CDC_SRC_ISOLATE_EN  when defined, isolate_i blocks pushes and isolated_o
//                       is a register reporting "isolation requested and every
//                       channel empty". When undefined, isolate_i is ignored
//                       and isolated_o is tied to 0 with no register behind it.
//
// Parameters:
//   NumChan    number of independent channels
//   DataWidth  payload width per channel
//   LogDepth   log2 of per-channel depth (minimum 1)
//   SyncStages read-pointer synchroniser length (minimum 2)
// -----------------------------------------------------------------------------
module cdc_src_mc #(
  parameter int unsigned NumChan    = 5,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned LogDepth   = 1,
  parameter int unsigned SyncStages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cdc_src_mc_if.slave      bus
);

  localparam int unsigned Depth = 2 ** LogDepth;
  localparam int unsigned PtrW  = LogDepth + 1;

  typedef logic [PtrW-1:0]      ptr_t;
  typedef logic [DataWidth-1:0] word_t;

  // Occupancy that marks a channel as full (half the pointer range).
  localparam ptr_t FullLevel = ptr_t'(Depth);

  // ---------------------------------------------------------------------------
  // Pointer encodings
  // ---------------------------------------------------------------------------
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at and above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PtrW-1] = g[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ptr_t  [NumChan-1:0]                  wbin_q, wbin_d;
  ptr_t  [NumChan-1:0]                  wptr_q, wptr_d;
  word_t [NumChan-1:0][Depth-1:0]       mem_q,  mem_d;
  ptr_t  [NumChan-1:0][SyncStages-1:0]  sync_q, sync_d;

  // ---------------------------------------------------------------------------
  // Per-channel status derived from registered values only
  // ---------------------------------------------------------------------------
  ptr_t [NumChan-1:0] rbin;
  ptr_t [NumChan-1:0] fill;
  logic [NumChan-1:0] full;
  logic [NumChan-1:0] ready;
  logic [NumChan-1:0] push;
  logic               accept_en;
  logic               all_empty;

`ifdef CDC_SRC_ISOLATE_EN
  assign accept_en = ~bus.isolate_i;
`else
  // isolate_i has no function in this build; the name keeps lint quiet.
  logic unused_isolate;
  assign unused_isolate = bus.isolate_i;
  assign accept_en      = 1'b1;
`endif

  // NOTE: every variable written in an always_comb gets a default before any
  // conditional assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rbin      = '0;
    fill      = '0;
    full      = '0;
    ready     = '0;
    push      = '0;
    all_empty = 1'b1;
    for (int unsigned c = 0; c < NumChan; c++) begin
      rbin[c]  = gray2bin(sync_q[c][SyncStages-1]);
      // Modular subtraction over LogDepth+1 bits handles pointer wrap.
      fill[c]  = wbin_q[c] - rbin[c];
      full[c]  = (fill[c] == FullLevel);
      // Ready is independent of valid; a pop still in the synchroniser does
      // not make a full channel ready (no bypass).
      ready[c] = ~full[c] & accept_en;
      push[c]  = bus.src_valid_i[c] & ready[c];
      if (fill[c] != '0) begin
        all_empty = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: storage, write pointers, read-pointer synchronisers
  // ---------------------------------------------------------------------------
  always_comb begin
    wbin_d = wbin_q;
    wptr_d = wptr_q;
    mem_d  = mem_q;
    sync_d = sync_q;
    for (int unsigned c = 0; c < NumChan; c++) begin
      // Read pointer enters the first stage straight from the other domain.
      sync_d[c][0] = bus.async_rptr_i[c];
      for (int s = 1; s < int'(SyncStages); s++) begin
        sync_d[c][s] = sync_q[c][s-1];
      end

      // Data and pointer move on the same edge; the slot addressed by the
      // low pointer bits is free because the channel is not full.
      if (push[c]) begin
        mem_d[c][wbin_q[c][LogDepth-1:0]] = bus.src_data_i[c];
        wbin_d[c] = wbin_q[c] + ptr_t'(1);
      end

      // Gray pointer is registered from the next binary value so it never
      // shows combinational glitches to the destination domain.
      wptr_d[c] = bin2gray(wbin_d[c]);
    end
  end

  // NOTE: storage is included in the asynchronous reset because the
  // destination reads it directly and must see defined words after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q <= '0;
      wptr_q <= '0;
      mem_q  <= '0;
      sync_q <= '0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wptr_d;
      mem_q  <= mem_d;
      sync_q <= sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Isolation status
  // ---------------------------------------------------------------------------
`ifdef CDC_SRC_ISOLATE_EN
  logic isolated_q, isolated_d;

  // Set one edge after "requested and drained" holds, cleared one edge after
  // the request drops.
  always_comb begin
    isolated_d = bus.isolate_i & all_empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      isolated_q <= 1'b0;
    end else begin
      isolated_q <= isolated_d;
    end
  end

  assign bus.isolated_o = isolated_q;
`else
  logic unused_all_empty;
  assign unused_all_empty = all_empty;
  assign bus.isolated_o   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.src_ready_o  = ready;
  assign bus.async_data_o = mem_q;
  assign bus.async_wptr_o = wptr_q;
  assign bus.fill_o       = fill;

endmodule

// File: tb/tb_cdc_src_mc.sv
// -----------------------------------------------------------------------------
// tb_cdc_src_mc
//
// Self-checking bench for cdc_src_mc. A behavioural model (write counters,
// a read-pointer delay line, storage array, per-channel data queues) predicts
// every output; a compare process checks the DUT against it on each falling
// edge. Directed sequences pin the model with literal expectations, then a
// randomized phase with a popping destination runs against the model.
// -----------------------------------------------------------------------------
module tb_cdc_src_mc;

  localparam int NC = 5;
  localparam int DW = 64;
  localparam int LD = 1;
  localparam int SS = 2;
  localparam int D  = 2 ** LD;
  localparam int M  = 2 * D;

`ifdef CDC_SRC_ISOLATE_EN
  localparam bit IsoEn = 1'b1;
`else
  localparam bit IsoEn = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  cdc_src_mc_if #(.NumChan(NC), .DataWidth(DW), .LogDepth(LD)) bus ();

  cdc_src_mc #(
    .NumChan   (NC),
    .DataWidth (DW),
    .LogDepth  (LD),
    .SyncStages(SS)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int x = g; x != 0; x = x >> 1) b ^= x;
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          m_wcnt [NC];
  int          m_hist [NC][$];   // decoded rptr values seen at past edges, newest first
  logic [63:0] m_mem  [NC][D];
  logic [63:0] sb     [NC][$];   // beats pushed and not yet popped
  bit          m_iso;

  function automatic int m_fill(input int c);
    return ((m_wcnt[c] - m_hist[c][SS-1]) % M + M) % M;
  endfunction

  function automatic bit m_ready(input int c);
    return (m_fill(c) != D) && !(IsoEn && bus.isolate_i);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_wcnt[c] = 0;
      m_hist[c].delete();
      for (int s = 0; s < SS; s++) m_hist[c].push_back(0);
      for (int w = 0; w < D; w++) m_mem[c][w] = '0;
    end
    m_iso = 1'b0;
  endtask

  task automatic model_step();
    bit all_empty = 1'b1;
    bit push [NC];
    for (int c = 0; c < NC; c++) begin
      if (m_fill(c) != 0) all_empty = 1'b0;
      push[c] = bus.src_valid_i[c] && m_ready(c);
    end
    for (int c = 0; c < NC; c++) begin
      if (push[c]) begin
        m_mem[c][m_wcnt[c] % D] = bus.src_data_i[c];
        sb[c].push_back(bus.src_data_i[c]);
        m_wcnt[c] = (m_wcnt[c] + 1) % M;
      end
      m_hist[c].push_front(g2b(int'(bus.async_rptr_i[c])));
      void'(m_hist[c].pop_back());
    end
    m_iso = IsoEn && bus.isolate_i && all_empty;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) model_reset();
      else         model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge out of reset
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        for (int c = 0; c < NC; c++) begin
          check($sformatf("ready[%0d]", c), bus.src_ready_o[c], m_ready(c));
          check($sformatf("wptr[%0d]", c),  bus.async_wptr_o[c], gray(m_wcnt[c]));
          check($sformatf("fill[%0d]", c),  bus.fill_o[c], m_fill(c));
          check($sformatf("fill_bound[%0d]", c), bus.fill_o[c] <= D, 1);
          for (int w = 0; w < D; w++)
            check($sformatf("data[%0d][%0d]", c, w), bus.async_data_o[c][w], m_mem[c][w]);
        end
        check("isolated", bus.isolated_o, m_iso);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  gseq [4];
  int          rd   [NC];
  logic [63:0] va, vb, vc;
  int          k, budget, base;
  bit          acc;

  initial begin
    gseq[0] = 2'b00; gseq[1] = 2'b01; gseq[2] = 2'b11; gseq[3] = 2'b10;
    va = 64'hAAAA_0000_0000_000A;
    vb = 64'hBBBB_0000_0000_000B;
    vc = 64'hCCCC_0000_0000_000C;

    bus.src_valid_i  = '0;
    bus.src_data_i   = '0;
    bus.async_rptr_i = '0;
    bus.isolate_i    = 1'b0;
    rst_ni           = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;

    // Reset state
    check("rst_wptr",     bus.async_wptr_o, '0);
    check("rst_fill",     bus.fill_o, '0);
    check("rst_ready",    bus.src_ready_o, 5'b11111);
    check("rst_isolated", bus.isolated_o, 0);
    check("rst_data",     bus.async_data_o[0][0], '0);

    // Fill channel 0: A, B accepted, C stalled
    bus.src_valid_i[0] = 1'b1;
    bus.src_data_i[0]  = va;
    #1 check("fill0_ready_a", bus.src_ready_o[0], 1);
    tick();
    check("fill0_wptr_a", bus.async_wptr_o[0], 2'b01);
    check("fill0_fill_a", bus.fill_o[0], 1);
    bus.src_data_i[0] = vb;
    tick();
    check("fill0_wptr_b", bus.async_wptr_o[0], 2'b11);
    check("fill0_fill_b", bus.fill_o[0], 2);
    check("fill0_ready_b", bus.src_ready_o[0], 0);
    bus.src_data_i[0] = vc;
    tick();
    check("fill0_wptr_stall", bus.async_wptr_o[0], 2'b11);
    check("fill0_slot0", bus.async_data_o[0][0], va);
    check("fill0_slot1", bus.async_data_o[0][1], vb);

    // Release one entry; visible two edges later, then C lands in slot 0
    bus.async_rptr_i[0] = 2'b01;
    tick();
    check("rel_fill_e1",  bus.fill_o[0], 2);
    check("rel_ready_e1", bus.src_ready_o[0], 0);
    tick();
    check("rel_fill_e2",  bus.fill_o[0], 1);
    check("rel_ready_e2", bus.src_ready_o[0], 1);
    tick();
    check("rel_slot0_c", bus.async_data_o[0][0], vc);
    check("rel_wptr_c",  bus.async_wptr_o[0], 2'b10);
    check("rel_fill_c",  bus.fill_o[0], 2);
    bus.src_valid_i[0]  = 1'b0;
    bus.async_rptr_i[0] = 2'b10;
    repeat (3) tick();
    check("drain0_fill", bus.fill_o[0], 0);

    // Wrap-around on channel 4 with a destination echoing wptr
    k = 0;
    budget = 0;
    bus.src_valid_i[4] = 1'b1;
    while (k < 10 && budget < 80) begin
      bus.src_data_i[4]   = 64'h4400 + 64'(k);
      bus.async_rptr_i[4] = bus.async_wptr_o[4];
      #1 acc = bus.src_ready_o[4];
      tick();
      if (acc) begin
        check($sformatf("wrap_slot_%0d", k), bus.async_data_o[4][k % D], 64'h4400 + 64'(k));
        check($sformatf("wrap_wptr_%0d", k), bus.async_wptr_o[4], gseq[(k + 1) % 4]);
        k++;
      end
      budget++;
    end
    check("wrap_count", k, 10);
    bus.src_valid_i[4]  = 1'b0;
    bus.async_rptr_i[4] = bus.async_wptr_o[4];
    repeat (3) tick();
    check("wrap_drained", bus.fill_o[4], 0);

    // Isolation with one entry pending on channel 1
    bus.src_valid_i[1] = 1'b1;
    bus.src_data_i[1]  = 64'h1111;
    tick();
    bus.src_valid_i[1] = 1'b0;
    check("iso_pending", bus.fill_o[1], 1);
    bus.isolate_i      = 1'b1;
    bus.src_valid_i[2] = 1'b1;
    bus.src_data_i[2]  = 64'h2222;
    #1;
    check("iso_ready",      bus.src_ready_o, IsoEn ? 5'b00000 : 5'b11111);
    check("iso_isolated_0", bus.isolated_o, 0);
    tick();
    check("iso_blocked", bus.async_wptr_o[2], IsoEn ? 2'b00 : 2'b01);
    bus.src_valid_i[2]  = 1'b0;
    bus.async_rptr_i[1] = 2'b01;
    tick();
    check("iso_e1", bus.isolated_o, 0);
    tick();
    check("iso_e2_fill", bus.fill_o[1], 0);
    check("iso_e2", bus.isolated_o, 0);
    tick();
    check("iso_e3", bus.isolated_o, IsoEn);
    bus.isolate_i = 1'b0;
    tick();
    check("iso_release", bus.isolated_o, 0);
    bus.async_rptr_i[2] = bus.async_wptr_o[2];
    repeat (3) tick();

    // Channel independence: 0 and 3 push while 2 is full
    base = IsoEn ? 0 : 1;
    bus.src_valid_i[2] = 1'b1;
    bus.src_data_i[2]  = 64'h2200;
    repeat (2) tick();
    #1;
    check("ind_full_ready2", bus.src_ready_o[2], 0);
    check("ind_full_fill2",  bus.fill_o[2], 2);
    check("ind_full_wptr2",  bus.async_wptr_o[2], gray((base + 2) % M));
    bus.src_valid_i[0] = 1'b1;
    bus.src_valid_i[3] = 1'b1;
    bus.src_data_i[0]  = 64'h0D0D;
    bus.src_data_i[3]  = 64'h3D3D;
    tick();
    check("ind_wptr0", bus.async_wptr_o[0], 2'b00);
    check("ind_wptr3", bus.async_wptr_o[3], 2'b01);
    check("ind_fill3", bus.fill_o[3], 1);
    check("ind_wptr2", bus.async_wptr_o[2], gray((base + 2) % M));
    check("ind_fill2", bus.fill_o[2], 2);
    bus.src_valid_i = '0;

    // Drain everything before the randomized phase
    for (int c = 0; c < NC; c++) begin
      rd[c] = m_wcnt[c];
      bus.async_rptr_i[c] = 2'(gray(rd[c]));
    end
    repeat (3) tick();
    for (int c = 0; c < NC; c++) sb[c].delete();

    // Randomized traffic with a popping destination and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_ni = 1'b0;
        #1;
        check("midrst_wptr", bus.async_wptr_o, '0);
        check("midrst_fill", bus.fill_o, '0);
        bus.src_valid_i  = '0;
        bus.async_rptr_i = '0;
        bus.isolate_i    = 1'b0;
        for (int c = 0; c < NC; c++) begin
          rd[c] = 0;
          sb[c].delete();
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
      end
      for (int c = 0; c < NC; c++) begin
        if (rd[c] != m_wcnt[c] && $urandom_range(0, 99) < 50) begin
          check($sformatf("sb_nonempty[%0d]", c), sb[c].size() != 0, 1);
          if (sb[c].size() != 0) begin
            check($sformatf("pop_data[%0d]", c), bus.async_data_o[c][rd[c] % D], sb[c][0]);
            void'(sb[c].pop_front());
          end
          rd[c] = (rd[c] + 1) % M;
          bus.async_rptr_i[c] = 2'(gray(rd[c]));
        end
        bus.src_valid_i[c] = ($urandom_range(0, 99) < 60);
        bus.src_data_i[c]  = {$urandom(), $urandom()};
      end
      bus.isolate_i = ($urandom_range(0, 99) < 8);
      tick();
    end

    bus.src_valid_i = '0;
    bus.isolate_i   = 1'b0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
